tl_countdown_display: RTL and testbench



---
 rtl/tl_countdown_display_pkg.sv | 31 +++
 rtl/tl_countdown_display_if.sv | 19 +
 rtl/tl_countdown_display_seg7_decode.sv | 29 ++
 rtl/tl_countdown_display.sv | 120 ++++++++++++
 tb/tb_tl_countdown_display.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/tl_countdown_display_pkg.sv
// Shared types and segment constants for the countdown display slice.
// Optional blink gating in the top is controlled by TL_COUNT_BLINK_EN.
package tl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HOLD
    } state_e;

    // Active-low segments, a..g on bit0..bit6
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_DIGIT [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    function automatic logic [3:0] bcd_tens(input logic [6:0] v);
        logic [6:0] t;
        t = v / 7'd10;
        return t[3:0];
    endfunction

    function automatic logic [3:0] bcd_ones(input logic [6:0] v);
        logic [6:0] t;
        t = v % 7'd10;
        return t[3:0];
    endfunction

endpackage

// File: rtl/tl_countdown_display_if.sv
// Upstream-facing bundle: controller tick/phase in, display and status out.
interface tl_countdown_display_if;
    logic       tick;
    logic       phase_x;
    logic [6:0] seg;
    logic [1:0] dig_n;
    logic [6:0] secs;
    logic       zero;

    modport master (
        output tick, phase_x,
        input  seg, dig_n, secs, zero
    );

    modport slave (
        input  tick, phase_x,
        output seg, dig_n, secs, zero
    );
endinterface

// File: rtl/tl_countdown_display_seg7_decode.sv
// Combinational BCD to active-low 7-segment decoder with blank override.
module seg7_decode
    import tl_pkg::*;
(
    input  logic [3:0] bcd_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        if (!blank_i) begin
            case (bcd_i)
                4'd0:    seg_o = SEG_DIGIT[0];
                4'd1:    seg_o = SEG_DIGIT[1];
                4'd2:    seg_o = SEG_DIGIT[2];
                4'd3:    seg_o = SEG_DIGIT[3];
                4'd4:    seg_o = SEG_DIGIT[4];
                4'd5:    seg_o = SEG_DIGIT[5];
                4'd6:    seg_o = SEG_DIGIT[6];
                4'd7:    seg_o = SEG_DIGIT[7];
                4'd8:    seg_o = SEG_DIGIT[8];
                4'd9:    seg_o = SEG_DIGIT[9];
                default: seg_o = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/tl_countdown_display.sv
// Phase countdown in whole seconds driving a 2-digit multiplexed 7-seg display.
// Define TL_COUNT_BLINK_EN to blank the display at 1 Hz during the last seconds of RUN.
module tl_countdown_display
    import tl_pkg::*;
#(
    parameter int unsigned TX       = 30,
    parameter int unsigned TY       = 15,
    parameter int unsigned SCAN_DIV = 1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    tl_countdown_display_if.slave bus
);

    localparam int unsigned SCW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    state_e           state_q, state_d;
    logic       [6:0] secs_q, secs_d;
    logic       [3:0] sub_q, sub_d;
    logic             zero_q, zero_d;
    logic             phase_q;
    logic   [SCW-1:0] scan_q, scan_d;
    logic             idx_q, idx_d;
    logic       [6:0] seg_q, seg_d;
    logic       [1:0] dig_n_q, dig_n_d;

    logic             rise, fall;
    logic       [3:0] tens, ones, dec_bcd;
    logic             dec_blank, blink;
    logic       [6:0] dec_seg;

    assign rise = bus.phase_x & ~phase_q;
    assign fall = ~bus.phase_x & phase_q;

    // A phase edge reloads and swallows any coincident tick
    always_comb begin
        state_d = state_q;
        secs_d  = secs_q;
        sub_d   = sub_q;
        if (rise || fall) begin
            secs_d  = rise ? 7'(TX) : 7'(TY);
            sub_d   = '0;
            state_d = RUN;
        end else if (bus.tick) begin
            if (sub_q == 4'd9) begin
                sub_d = '0;
                if (secs_q != '0) begin
                    secs_d = secs_q - 7'd1;
                    if (secs_q == 7'd1 && state_q == RUN) begin
                        state_d = HOLD;
                    end
                end
            end else begin
                sub_d = sub_q + 4'd1;
            end
        end
        zero_d = (state_d == HOLD);
    end

    always_comb begin
        if (scan_q == SCW'(SCAN_DIV - 1)) begin
            scan_d = '0;
            idx_d  = ~idx_q;
        end else begin
            scan_d = scan_q + SCW'(1);
            idx_d  = idx_q;
        end
    end

`ifdef TL_COUNT_BLINK_EN
    assign blink = (state_q == RUN) && (secs_q <= 7'd4) && (sub_q >= 4'd5);
`else
    assign blink = 1'b0;
`endif

    assign tens      = bcd_tens(secs_q);
    assign ones      = bcd_ones(secs_q);
    assign dec_bcd   = idx_q ? tens : ones;
    assign dec_blank = (idx_q && tens == 4'd0) || blink;

    seg7_decode u_dec (
        .bcd_i   (dec_bcd),
        .blank_i (dec_blank),
        .seg_o   (dec_seg)
    );

    // seg and dig_n both derive from idx_q so the pair always switches together
    assign seg_d   = (state_q == IDLE) ? SEG_DASH : dec_seg;
    assign dig_n_d = idx_q ? 2'b01 : 2'b10;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            secs_q  <= '0;
            sub_q   <= '0;
            zero_q  <= 1'b0;
            phase_q <= 1'b0;
            scan_q  <= '0;
            idx_q   <= 1'b0;
            seg_q   <= SEG_BLANK;
            dig_n_q <= '1;
        end else begin
            state_q <= state_d;
            secs_q  <= secs_d;
            sub_q   <= sub_d;
            zero_q  <= zero_d;
            phase_q <= bus.phase_x;
            scan_q  <= scan_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            dig_n_q <= dig_n_d;
        end
    end

    assign bus.seg   = seg_q;
    assign bus.dig_n = dig_n_q;
    assign bus.secs  = secs_q;
    assign bus.zero  = zero_q;

endmodule

// File: tb/tb_tl_countdown_display.sv
// Directed table-driven bench for tl_countdown_display (SCAN_DIV=4, TX=30, TY=15).
module tb_tl_countdown_display;

    localparam logic [6:0] S_BLANK = 7'h7F;
    localparam logic [6:0] S_DASH  = 7'b0111111;
    localparam logic [6:0] S_1     = 7'b1111001;
    localparam logic [6:0] S_4     = 7'b0011001;
    localparam logic [6:0] S_5     = 7'b0010010;
    localparam logic [6:0] S_7     = 7'b1111000;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   cyc;

    tl_countdown_display_if bus_if ();

    tl_countdown_display #(
        .TX       (30),
        .TY       (15),
        .SCAN_DIV (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-running edge count since reset release, used to predict the scan slot
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    typedef struct {
        logic        ph;
        int unsigned nticks;
        int unsigned exp_secs;
        logic        exp_zero;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc1(input logic tk);
        bus_if.tick = tk;
        @(posedge clk);
        @(negedge clk);
        bus_if.tick = 1'b0;
    endtask

    task automatic do_ticks(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            cyc1(1'b1);
            cyc1(1'b0);
        end
    endtask

    task automatic set_phase(input logic p);
        bus_if.phase_x = p;
        cyc1(1'b0);
    endtask

    task automatic check_display(input logic [6:0] tens_exp, input logic [6:0] ones_exp,
                                 input int unsigned n);
        int idx;
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            idx = ((cyc - 1) / 4) % 2;
            chk("dig_n", int'(bus_if.dig_n), idx ? 1 : 2);
            chk(idx ? "seg_tens" : "seg_ones", int'(bus_if.seg),
                idx ? int'(tens_exp) : int'(ones_exp));
        end
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        rst_n          = 1'b0;
        bus_if.tick    = 1'b0;
        bus_if.phase_x = 1'b0;

        vecs[0] = '{1'b1, 0,   30, 1'b0};
        vecs[1] = '{1'b1, 10,  29, 1'b0};
        vecs[2] = '{1'b1, 290, 0,  1'b1};
        vecs[3] = '{1'b1, 20,  0,  1'b1};
        vecs[4] = '{1'b0, 0,   15, 1'b0};
        vecs[5] = '{1'b0, 25,  13, 1'b0};
        vecs[6] = '{1'b1, 0,   30, 1'b0};
        vecs[7] = '{1'b1, 7,   30, 1'b0};

        repeat (3) @(negedge clk);
        chk("rst_seg", int'(bus_if.seg), int'(S_BLANK));
        chk("rst_dig_n", int'(bus_if.dig_n), 3);
        chk("rst_secs", int'(bus_if.secs), 0);
        chk("rst_zero", int'(bus_if.zero), 0);
        rst_n = 1'b1;

        check_display(S_DASH, S_DASH, 16);
        chk("idle_secs", int'(bus_if.secs), 0);
        chk("idle_zero", int'(bus_if.zero), 0);

        for (int i = 0; i < 8; i++) begin
            if (vecs[i].ph != bus_if.phase_x) set_phase(vecs[i].ph);
            do_ticks(vecs[i].nticks);
            chk($sformatf("vec%0d_secs", i), int'(bus_if.secs), int'(vecs[i].exp_secs));
            chk($sformatf("vec%0d_zero", i), int'(bus_if.zero), int'(vecs[i].exp_zero));
        end

        // Reach secs=3 with sub=9, then coincident edge and tick
        set_phase(1'b0);
        set_phase(1'b1);
        do_ticks(270);
        chk("pre_secs3", int'(bus_if.secs), 3);
        do_ticks(9);
        chk("sub9_secs3", int'(bus_if.secs), 3);
        bus_if.phase_x = 1'b0;
        cyc1(1'b1);
        chk("edge_tick_secs", int'(bus_if.secs), 15);
        chk("edge_tick_zero", int'(bus_if.zero), 0);

        check_display(S_1, S_5, 8);

        do_ticks(9);
        chk("sub_cleared", int'(bus_if.secs), 15);
        do_ticks(1);
        chk("first_dec", int'(bus_if.secs), 14);

        do_ticks(70);
        chk("secs7", int'(bus_if.secs), 7);
        check_display(S_BLANK, S_7, 8);

        do_ticks(35);
        chk("secs4", int'(bus_if.secs), 4);
`ifdef TL_COUNT_BLINK_EN
        check_display(S_BLANK, S_BLANK, 8);
`else
        check_display(S_BLANK, S_4, 8);
`endif

        set_phase(1'b1);
        do_ticks(180);
        chk("secs12", int'(bus_if.secs), 12);

        // Asynchronous reset away from any clock edge
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_seg", int'(bus_if.seg), int'(S_BLANK));
        chk("arst_dig_n", int'(bus_if.dig_n), 3);
        chk("arst_secs", int'(bus_if.secs), 0);
        chk("arst_zero", int'(bus_if.zero), 0);
        @(negedge clk);
        @(negedge clk);
        chk("arst_hold_secs", int'(bus_if.secs), 0);
        rst_n = 1'b1;
        cyc1(1'b0);
        chk("rise_after_rst", int'(bus_if.secs), 30);
        chk("rise_after_rst_zero", int'(bus_if.zero), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
